// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: receives 5-byte command frames (SYNC, ADDR, DATA_HI, DATA_LO, CHK)
// from a UART byte stream and issues register writes for frames whose checksum matches.
// Ports:
//   i_clk_50    - system clock
//   i_rst_n     - asynchronous active-low reset
//   i_rx_dv     - byte-valid strobe; every high cycle is one byte
//   i_rx_byte   - received byte, valid while i_rx_dv=1
//   o_wr_en     - one-cycle register-write strobe
//   o_wr_addr   - address of the last good frame
//   o_wr_data   - data of the last good frame
//   o_frame_err - one-cycle strobe on checksum failure or inter-byte timeout
//   o_err_count - saturating frame-error count
//   o_busy      - high while a frame is in progress
module cmd_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic        i_clk_50,
    input  logic        i_rst_n,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_frame_err,
    output logic [7:0]  o_err_count,
    output logic        o_busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_ADDR = 3'd1;
    localparam logic [2:0] GET_HI   = 3'd2;
    localparam logic [2:0] GET_LO   = 3'd3;
    localparam logic [2:0] GET_CHK  = 3'd4;

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_next;
    logic [7:0]       addr_q, addr_next;
    logic [7:0]       hi_q, hi_next;
    logic [7:0]       lo_q, lo_next;
    logic             wr_en_next;
    logic [7:0]       wr_addr_next;
    logic [15:0]      wr_data_next;
    logic             frame_err_next;
    logic [7:0]       err_count_next;
    logic             busy_next;
    logic [7:0]       sum;
    logic             timeout;

    assign sum = addr_q + hi_q + lo_q;

    // An arriving byte suppresses the timeout in the same cycle.
    assign timeout = (state != IDLE) && !i_rx_dv && (tmo_cnt == CNT_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state;
        tmo_cnt_next   = tmo_cnt;
        addr_next      = addr_q;
        hi_next        = hi_q;
        lo_next        = lo_q;
        wr_en_next     = 1'b0;
        wr_addr_next   = o_wr_addr;
        wr_data_next   = o_wr_data;
        frame_err_next = 1'b0;
        err_count_next = o_err_count;

        if (state == IDLE || i_rx_dv) begin
            tmo_cnt_next = '0;
        end else begin
            tmo_cnt_next = tmo_cnt + CNT_W'(1);
        end

        if (i_rx_dv) begin
            case (state)
                IDLE: begin
                    if (i_rx_byte == SYNC_BYTE) begin
                        state_next = GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    addr_next  = i_rx_byte;
                    state_next = GET_HI;
                end
                GET_HI: begin
                    hi_next    = i_rx_byte;
                    state_next = GET_LO;
                end
                GET_LO: begin
                    lo_next    = i_rx_byte;
                    state_next = GET_CHK;
                end
                GET_CHK: begin
                    if (i_rx_byte == sum) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = addr_q;
                        wr_data_next = {hi_q, lo_q};
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            frame_err_next = 1'b1;
            state_next     = IDLE;
        end

        if (frame_err_next && (o_err_count != 8'hFF)) begin
            err_count_next = o_err_count + 8'd1;
        end

        busy_next = (state_next != IDLE);
    end

    // State, payload and output registers.
    always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            addr_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_frame_err <= 1'b0;
            o_err_count <= '0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_next;
            tmo_cnt     <= tmo_cnt_next;
            addr_q      <= addr_next;
            hi_q        <= hi_next;
            lo_q        <= lo_next;
            o_wr_en     <= wr_en_next;
            o_wr_addr   <= wr_addr_next;
            o_wr_data   <= wr_data_next;
            o_frame_err <= frame_err_next;
            o_err_count <= err_count_next;
            o_busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Testbench for cmd_frame_rx: directed frames, a scoreboard of expected write/error
// events, and checks of counters, busy and reset behaviour.
module tb_cmd_frame_rx;

    localparam int unsigned TO   = 40;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  rx = 8'h00;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    cmd_frame_rx #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk_50    (clk),
        .i_rst_n     (rst_n),
        .i_rx_dv     (dv),
        .i_rx_byte   (rx),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_frame_err (frame_err),
        .o_err_count (err_count),
        .o_busy      (busy)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  m_cnt  = 8'h00;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write/error strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (wr_en || frame_err)) begin
            check("strobe_excl", 32'(wr_en & frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_evt", 32'({wr_en, frame_err}), 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("evt_err", 32'(frame_err), 32'(e.err));
                check("evt_wr_en", 32'(wr_en), 32'(!e.err));
                check("evt_addr", 32'(wr_addr), 32'(e.addr));
                check("evt_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dv = 1'b1;
        rx = b;
        @(posedge clk);
        #1;
        dv = 1'b0;
        rx = 8'h00;
    endtask

    task automatic hold_byte(input logic [7:0] b, input int n);
        @(negedge clk);
        dv = 1'b1;
        rx = b;
        repeat (n) @(posedge clk);
        #1;
        dv = 1'b0;
        rx = 8'h00;
    endtask

    // Update the model with the outcome of a frame and queue the expected event.
    task automatic expect_frame(input logic [7:0] a, input logic [7:0] h,
                                input logic [7:0] l, input logic [7:0] c);
        ev_t e;
        if (c == 8'(a + h + l)) begin
            m_addr = a;
            m_data = {h, l};
            e.err  = 1'b0;
        end else begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            e.err = 1'b1;
        end
        e.addr = m_addr;
        e.data = m_data;
        exp_q.push_back(e);
    endtask

    task automatic settle_checks(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_errcnt"}, 32'(err_count), 32'(m_cnt));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c);
        expect_frame(a, h, l, c);
        send_byte(SYNC);
        check({tag, "_busy_mid"}, 32'(busy), 32'd1);
        send_byte(a);
        send_byte(h);
        send_byte(l);
        send_byte(c);
        settle_checks(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame, then bad checksum keeping the prior write values.
        send_frame("good", 8'h10, 8'h36, 8'hB0, 8'hF6);
        send_frame("badchk", 8'h10, 8'h36, 8'hB0, 8'hF7);

        // Leading garbage then SYNC bytes used as payload.
        send_byte(8'h00);
        send_byte(8'hFF);
        @(negedge clk);
        check("garbage_busy", 32'(busy), 32'd0);
        send_frame("sync_payload", 8'hA5, 8'hA5, 8'h01, 8'h4B);

        // Held strobe: each high cycle is one byte (ADDR, HI, LO all 0x10).
        expect_frame(8'h10, 8'h10, 8'h10, 8'h30);
        send_byte(SYNC);
        hold_byte(8'h10, 3);
        send_byte(8'h30);
        settle_checks("held_dv");

        // Timeout after A5 22: error exactly TO cycles after the last byte.
        expect_frame(8'h22, 8'h00, 8'h00, 8'hFF);
        send_byte(SYNC);
        send_byte(8'h22);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("tmo_not_early", 32'(exp_q.size()), 32'd1);
        check("tmo_busy_before", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("tmo_fired", 32'(exp_q.size()), 32'd0);
        settle_checks("tmo");
        send_frame("after_tmo", 8'h44, 8'h12, 8'h34, 8'h8A);

        // Byte arriving on the expiry cycle wins over the timeout.
        expect_frame(8'h22, 8'h33, 8'h44, 8'h99);
        send_byte(SYNC);
        send_byte(8'h22);
        repeat (TO - 1) @(posedge clk);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h99);
        settle_checks("expiry_byte");

        // Reset mid-frame abandons the frame.
        send_byte(SYNC);
        send_byte(8'h10);
        send_byte(8'h36);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("mrst_wr_en", 32'(wr_en), 32'd0);
        check("mrst_addr", 32'(wr_addr), 32'd0);
        check("mrst_data", 32'(wr_data), 32'd0);
        check("mrst_err", 32'(frame_err), 32'd0);
        check("mrst_errcnt", 32'(err_count), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        rst_n  = 1'b1;
        m_cnt  = 8'h00;
        m_addr = 8'h00;
        m_data = 16'h0000;
        send_byte(8'hB0);
        send_byte(8'hF6);
        repeat (3) @(negedge clk);
        check("mrst_addr_after", 32'(wr_addr), 32'd0);
        settle_checks("mrst");

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            a = 8'(i);
            send_frame("sat", a, 8'h5A, 8'h3C, 8'(a + 8'h5A + 8'h3C + 8'h01));
        end
        check("sat_final", 32'(err_count), 32'hFF);
        send_frame("sat_good", 8'h77, 8'h01, 8'h02, 8'h7A);
        check("sat_hold", 32'(err_count), 32'hFF);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
